// File: rtl/max7219_pkg.sv
// Shared constants for the MAX7219 SPI listener: register addresses,
// receiver FSM states and the default frame length.
package max7219_pkg;

  localparam int FRAME_BITS_DEF = 16;

  localparam logic [3:0] ADDR_NOOP      = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
  localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
  localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
  localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
  localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
  localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
  localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
  localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIM   = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_TEST      = 4'hF;

  typedef enum logic [1:0] {
    ST_WAIT_IDLE,
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_t;

endpackage

// File: rtl/max7219_spi_receiver_if.sv
// The three MAX7219 SPI wires plus the daisy-chain output, seen from the
// bus master and from the listening receiver.
interface max7219_spi_receiver_if;
   logic sclk;
   logic mosi;
   logic cs;
   logic dout;

   modport master (output sclk, output mosi, output cs, input dout);
   modport slave  (input sclk, input mosi, input cs, output dout);
endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, followed by a one-clock
// edge detector producing rise/fall pulses on the synchronized level.
module sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   prev;

   // NOTE: non-blocking assignments keep every flop sampling the pre-edge value, which is what makes this a shift chain.
   always_ff @(posedge clk) begin
      if (reset) begin
         chain <= '0;
         prev  <= 1'b0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], d};
         prev  <= chain[SYNC_STAGES-1];
      end
   end

   assign level = chain[SYNC_STAGES-1];
   assign rise  = level & ~prev;
   assign fall  = ~level & prev;

endmodule

// File: rtl/max7219_spi_receiver.sv
// Passive MAX7219 SPI listener: decodes 16-bit frames into the register file
// and presents the blanked row image one row at a time.
module max7219_spi_receiver
   import max7219_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FRAME_BITS  = FRAME_BITS_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   max7219_spi_receiver_if.slave      spi,
   input  logic [2:0]                 row_sel,
   output logic [7:0]                 row_data,
   output logic                       frame_valid,
   output logic [3:0]                 frame_addr,
   output logic [7:0]                 frame_data,
   output logic                       frame_err,
   output logic                       disp_on,
   output logic [7:0]                 decode_mode,
   output logic [3:0]                 intensity,
   output logic [2:0]                 scan_limit,
   output logic                       display_test
);

   localparam int CNT_W = 5;

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic mosi_lvl, mosi_rise, mosi_fall;
   logic cs_lvl, cs_rise, cs_fall;
   logic unused_mosi_edges;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(clk), .reset(reset), .d(spi.sclk),
      .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
      .clk(clk), .reset(reset), .d(spi.mosi),
      .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));
   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
      .clk(clk), .reset(reset), .d(spi.cs),
      .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));

   assign unused_mosi_edges = mosi_rise | mosi_fall | sclk_lvl;

   state_t                  state, state_nxt;
   logic [FRAME_BITS-1:0]   shreg;
   logic [CNT_W-1:0]        bit_cnt;
   logic                    dout_q;
   logic [7:0]              rows [8];
   logic [7:0]              row_eff;
   logic                    start, shift_en, fall_en, commit_ok, commit_err;
   logic [3:0]              addr;
   logic [7:0]              data;

   assign addr     = shreg[11:8];
   assign data     = shreg[7:0];
   assign spi.dout = dout_q;

   // NOTE: every signal written here gets a default first so no path leaves it unassigned and infers a latch.
   always_comb begin
      state_nxt  = state;
      start      = 1'b0;
      shift_en   = 1'b0;
      fall_en    = 1'b0;
      commit_ok  = 1'b0;
      commit_err = 1'b0;
      unique case (state)
         ST_WAIT_IDLE: if (cs_lvl) state_nxt = ST_IDLE;
         ST_IDLE: begin
            if (cs_fall) begin
               start     = 1'b1;
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // A cs rise in the same sample as an sclk rise ends the frame first.
            fall_en  = sclk_fall;
            shift_en = sclk_rise & ~cs_rise;
            if (cs_rise) state_nxt = ST_COMMIT;
         end
         ST_COMMIT: begin
            commit_ok  = (bit_cnt >= CNT_W'(FRAME_BITS));
            commit_err = ~commit_ok;
            state_nxt  = ST_IDLE;
         end
         default: state_nxt = ST_WAIT_IDLE;
      endcase
   end

   always_comb begin
      row_eff = rows[row_sel];
      if (display_test)           row_eff = 8'hFF;
      else if (!disp_on)          row_eff = 8'h00;
      else if (row_sel > scan_limit) row_eff = 8'h00;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_WAIT_IDLE;
         shreg        <= '0;
         bit_cnt      <= '0;
         dout_q       <= 1'b0;
         frame_valid  <= 1'b0;
         frame_err    <= 1'b0;
         frame_addr   <= '0;
         frame_data   <= '0;
         disp_on      <= 1'b0;
         decode_mode  <= '0;
         intensity    <= '0;
         scan_limit   <= '0;
         display_test <= 1'b0;
         row_data     <= '0;
         // NOTE: the digit rows are architecturally visible after reset, so this small array is reset like any register.
         for (int i = 0; i < 8; i++) rows[i] <= '0;
      end else begin
         state       <= state_nxt;
         frame_valid <= commit_ok;
         frame_err   <= commit_err;
         row_data    <= row_eff;

         if (start) begin
            bit_cnt <= '0;
         end else if (shift_en) begin
            shreg <= {shreg[FRAME_BITS-2:0], mosi_lvl};
            if (bit_cnt != '1) bit_cnt <= bit_cnt + 1'b1;
         end

         if (fall_en) dout_q <= shreg[FRAME_BITS-1];

         if (commit_ok) begin
            frame_addr <= addr;
            frame_data <= data;
            case (addr)
               ADDR_DECODE:    decode_mode  <= data;
               ADDR_INTENSITY: intensity    <= data[3:0];
               ADDR_SCANLIM:   scan_limit   <= data[2:0];
               ADDR_SHUTDOWN:  disp_on      <= data[0];
               ADDR_TEST:      display_test <= data[0];
               default: begin
                  // No-op and the unused 0xD/0xE addresses fall through untouched.
                  if (addr >= ADDR_DIGIT0 && addr <= ADDR_DIGIT7)
                     rows[3'(addr - ADDR_DIGIT0)] <= data;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_max7219_spi_receiver.sv
// Directed bench for the MAX7219 listener: a register-level model of the chip
// tracks every frame and is compared against the outputs on every quiet cycle.
module tb_max7219_spi_receiver;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] row_sel;
   logic [7:0] row_data;
   logic       frame_valid, frame_err, disp_on, display_test;
   logic [3:0] frame_addr, intensity;
   logic [7:0] frame_data, decode_mode;
   logic [2:0] scan_limit;

   max7219_spi_receiver_if spi ();

   max7219_spi_receiver dut (
      .clk(clk), .reset(reset), .spi(spi),
      .row_sel(row_sel), .row_data(row_data),
      .frame_valid(frame_valid), .frame_addr(frame_addr), .frame_data(frame_data),
      .frame_err(frame_err), .disp_on(disp_on), .decode_mode(decode_mode),
      .intensity(intensity), .scan_limit(scan_limit), .display_test(display_test));

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Chip model: registers as the datasheet describes them.
   logic [7:0] m_rows [8];
   logic       m_disp, m_test;
   logic [7:0] m_decode, m_data;
   logic [3:0] m_int, m_addr;
   logic [2:0] m_scan;
   bit         hist [$];

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_rows[i] = 8'h00;
      m_disp = 0; m_test = 0; m_decode = 0; m_int = 0; m_scan = 0;
      m_addr = 0; m_data = 0;
      hist.delete();
   endtask

   task automatic model_apply(input logic [15:0] w);
      int a;
      a = int'(w[11:8]);
      m_addr = w[11:8];
      m_data = w[7:0];
      if (a >= 1 && a <= 8) m_rows[a-1] = w[7:0];
      else if (a == 9)      m_decode = w[7:0];
      else if (a == 10)     m_int = w[3:0];
      else if (a == 11)     m_scan = w[2:0];
      else if (a == 12)     m_disp = w[0];
      else if (a == 15)     m_test = w[0];
   endtask

   function automatic logic [7:0] model_row(input logic [2:0] s);
      if (m_test)                return 8'hFF;
      if (!m_disp)               return 8'h00;
      if (int'(s) > int'(m_scan)) return 8'h00;
      return m_rows[s];
   endfunction

   // Pulse monitor and the every-cycle comparison while the bus is quiet.
   int         nv = 0, ne = 0;
   bit         settled = 0;
   logic [2:0] sel_q;

   always @(posedge clk) sel_q = row_sel;

   always @(negedge clk) begin
      if (!reset) begin
         if (frame_valid) nv++;
         if (frame_err) ne++;
      end
      if (settled && !reset) begin
         check("row_data", row_data, model_row(sel_q));
         check("disp_on", disp_on, m_disp);
         check("intensity", intensity, m_int);
         check("scan_limit", scan_limit, m_scan);
         check("display_test", display_test, m_test);
         check("decode_mode", decode_mode, m_decode);
         check("frame_addr", frame_addr, m_addr);
         check("frame_data", frame_data, m_data);
         check("idle_valid", frame_valid, 1'b0);
         check("idle_err", frame_err, 1'b0);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Sends nbits of w MSB first; rst_at>0 pulses reset after that many bits.
   task automatic send_frame(input logic [31:0] w, input int nbits, input int rst_at,
                             output logic [7:0] dbyte);
      int  nv0, ne0, exp_v, exp_e;
      bit  aborted, b;
      settled = 0;
      nv0 = nv; ne0 = ne; aborted = 0; dbyte = 8'h00;
      spi.cs = 1'b0;
      tick(6);
      for (int i = 0; i < nbits; i++) begin
         b = w[nbits-1-i];
         spi.mosi = b;
         tick(6);
         spi.sclk = 1'b1;
         tick(6);
         if (!aborted) hist.push_back(b);
         spi.sclk = 1'b0;
         tick(6);
         if (!aborted && hist.size() >= 16) check("dout", spi.dout, hist[hist.size()-16]);
         if (i >= 15 && i < 23) dbyte = {dbyte[6:0], spi.dout};
         if (i + 1 == rst_at) begin
            reset = 1'b1;
            tick(2);
            reset = 1'b0;
            model_reset();
            aborted = 1;
         end
      end
      spi.mosi = 1'b0;
      spi.cs = 1'b1;
      tick(8);
      exp_v = 0; exp_e = 0;
      if (!aborted) begin
         if (nbits >= 16) begin
            model_apply(w[15:0]);
            exp_v = 1;
         end else begin
            exp_e = 1;
         end
      end
      check("valid_pulses", nv - nv0, exp_v);
      check("err_pulses", ne - ne0, exp_e);
      settled = 1;
      tick(4);
   endtask

   logic [15:0] init_seq [5] = '{16'h0C01, 16'h0900, 16'h0A0A, 16'h0B07, 16'h0F00};
   logic [15:0] row_seq  [8] = '{16'h01FF, 16'h0281, 16'h0342, 16'h0424,
                                 16'h0518, 16'h063C, 16'h077E, 16'h08F0};
   logic [7:0]  row_exp  [8] = '{8'hFF, 8'h81, 8'h42, 8'h24, 8'h18, 8'h3C, 8'h7E, 8'hF0};

   initial begin
      logic [7:0] db;
      int v0;
      reset = 1'b1; row_sel = 3'd0;
      spi.sclk = 1'b0; spi.mosi = 1'b0; spi.cs = 1'b1;
      model_reset();
      tick(3);
      reset = 1'b0;
      tick(2);
      settled = 1;
      tick(4);
      check("reset_row_data", row_data, 8'h00);
      check("reset_disp_on", disp_on, 1'b0);

      v0 = nv;
      foreach (init_seq[i]) send_frame({16'h0, init_seq[i]}, 16, 0, db);
      check("init_pulses", nv - v0, 5);
      check("init_disp_on", disp_on, 1'b1);
      check("init_intensity", intensity, 4'hA);
      check("init_scan_limit", scan_limit, 3'd7);
      check("init_test", display_test, 1'b0);

      foreach (row_seq[i]) send_frame({16'h0, row_seq[i]}, 16, 0, db);
      for (int s = 0; s < 8; s++) begin
         row_sel = 3'(s);
         tick(1);
         check("row_sweep", row_data, row_exp[s]);
      end

      send_frame(32'h0C, 8, 0, db);
      check("short_disp_on", disp_on, 1'b1);
      check("short_intensity", intensity, 4'hA);

      send_frame(32'hAA0301, 24, 0, db);
      check("long_addr", frame_addr, 4'h3);
      check("long_data", frame_data, 8'h01);
      check("long_dout_byte", db, 8'hAA);

      row_sel = 3'd5;
      send_frame(32'h0B02, 16, 0, db);
      check("row5_beyond_scan", row_data, 8'h00);
      send_frame(32'h0F01, 16, 0, db);
      check("row5_test_on", row_data, 8'hFF);
      send_frame(32'h0C00, 16, 0, db);
      check("row5_test_over_shutdown", row_data, 8'hFF);
      send_frame(32'h0C01, 16, 0, db);
      send_frame(32'h0F00, 16, 0, db);
      check("row5_test_off", row_data, 8'h00);
      send_frame(32'h0B07, 16, 0, db);
      check("row5_visible", row_data, 8'h3C);

      v0 = nv;
      send_frame(32'h0C01, 16, 9, db);
      check("abort_pulses", nv - v0, 0);
      check("abort_disp_on", disp_on, 1'b0);
      check("abort_row_data", row_data, 8'h00);
      send_frame(32'h0C01, 16, 0, db);
      check("recover_pulses", nv - v0, 1);
      check("recover_disp_on", disp_on, 1'b1);

      settled = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
